// File: rtl/bpb_update_ctrl.sv
// BPB write side: queues resolved branches, looks each up against all lines and issues one w_en/sw pulse.
// Latency 3 cycles push->pulse, 1 record per 3 cycles; upd_ready low while the FIFO is full.
// Optional hit/miss/drop statistics are built only when BPB_STATS_EN is defined.
module bpb_update_ctrl #(
    parameter int ENTRIES    = 16,
    parameter int TAG_WIDTH  = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic                         upd_is_br,
    input  logic [31:0]                  upd_pc,
    input  logic                         upd_taken,
    input  logic [31:0]                  upd_target,
    input  logic [ENTRIES-1:0]           line_valid,
    input  logic [ENTRIES*TAG_WIDTH-1:0] line_tag,
    input  logic [ENTRIES*32-1:0]        line_addr,
    output logic [ENTRIES-1:0]           w_en,
    output logic [ENTRIES-1:0]           sw,
    output logic                         taken,
    output logic                         set_valid,
    output logic [TAG_WIDTH-1:0]         set_tag,
    output logic [31:0]                  set_addr,
    output logic                         busy,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt,
    output logic [31:0]                  drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic                 taken;
        logic [31:0]          target;
    } rec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t      state;
    rec_t        fifo_mem [FIFO_DEPTH];
    rec_t        in_rec;
    rec_t        req;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    logic          hit;
    logic          free;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] victim;
    logic [31:0]   hit_addr;
    logic          unused_pc;

    // PC bits outside the tag field carry no information for the line array.
    assign unused_pc = ^upd_pc;

    always_comb begin
        in_rec        = '0;
        in_rec.tag    = upd_pc[TAG_WIDTH+1:2];
        in_rec.taken  = upd_taken;
        in_rec.target = upd_target;
    end

    // Wrap bit in each pointer separates full from empty.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign upd_ready = ~full;
    assign push      = upd_valid && upd_ready && upd_is_br;
    assign pop       = (state == IDLE) && !empty;
    assign busy      = !empty || (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= in_rec;
    end

    // Scan downwards so the lowest matching / lowest free index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        free    = 1'b0;
        victim  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (line_valid[i] && (line_tag[i*TAG_WIDTH +: TAG_WIDTH] == req.tag)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!line_valid[i]) begin
                free   = 1'b1;
                victim = IW'(i);
            end
        end
    end

    assign hit_addr = line_addr[32*hit_idx +: 32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req       <= '0;
            w_en      <= '0;
            sw        <= '0;
            taken     <= 1'b0;
            set_valid <= 1'b0;
            set_tag   <= '0;
            set_addr  <= '0;
        end else begin
            w_en <= '0;
            sw   <= '0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        req   <= fifo_mem[rd_ptr[AW-1:0]];
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= ISSUE;
                    if (hit) begin
                        if (req.taken && (hit_addr != req.target)) begin
                            w_en[hit_idx] <= 1'b1;
                            set_valid     <= 1'b1;
                            set_tag       <= req.tag;
                            set_addr      <= req.target;
                        end else begin
                            sw[hit_idx] <= 1'b1;
                            taken       <= req.taken;
                        end
                    end else if (req.taken && free) begin
                        w_en[victim] <= 1'b1;
                        set_valid    <= 1'b1;
                        set_tag      <= req.tag;
                        set_addr     <= req.target;
                    end
                end
                ISSUE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BPB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            drop_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != 32'hFFFF_FFFF)
                    hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF)
                    miss_cnt <= miss_cnt + 32'd1;
                if (req.taken && !free && (drop_cnt != 32'hFFFF_FFFF))
                    drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule
